// File: rtl/capture_ctrl.sv
// capture_ctrl: arm/trigger/post-count capture sequencer feeding the memory write stream.
// Define CAPTURE_CTRL_PRE_EN to build the pre-trigger fill gate (pre_cnt).
module capture_ctrl #(
    parameter int SDW = 32,
    parameter int CNW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ctl_arm,
    input  logic           ctl_abort,
    input  logic [CNW-1:0] cfg_pre,
    input  logic [CNW-1:0] cfg_post,
    output logic           ctl_run,
    output logic           sts_armed,
    output logic           sts_trig,
    output logic           sts_done,
    output logic           sts_abort,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic           sti_trigger,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_tlast,
    output logic [SDW-1:0] sto_tdata
);
    typedef enum logic [2:0] {IDLE, ARMED, TRIG, STOP, DONE} state_t;
    state_t state_q, state_d;
    logic vld_q, vld_d, last_q, last_d;
    logic [SDW-1:0] data_q, data_d;
    logic [CNW-1:0] post_q, post_d;
    logic armed_q, armed_d, trig_q, trig_d, done_q, done_d, abrt_q, abrt_d;
    logic active, acc, load, gate, beat_last;
`ifdef CAPTURE_CTRL_PRE_EN
    logic [CNW-1:0] pre_q, pre_d;
    assign gate = pre_q >= cfg_pre;
`else
    logic unused_cfg_pre;
    assign unused_cfg_pre = ^cfg_pre;
    assign gate = 1'b1;
`endif
    assign active = state_q == ARMED || state_q == TRIG;
    // abort blocks acceptance so the aborting cycle never loads a fresh beat
    assign sti_tready = (state_q == IDLE || state_q == DONE) ? 1'b1 :
                        active ? (!vld_q || sto_tready) && !ctl_abort : 1'b0;
    assign acc  = sti_tvalid && sti_tready;
    assign load = active && acc;
    assign ctl_run    = active;
    assign sts_armed  = armed_q;
    assign sts_trig   = trig_q;
    assign sts_done   = done_q;
    assign sts_abort  = abrt_q;
    assign sto_tvalid = vld_q;
    assign sto_tlast  = last_q;
    assign sto_tdata  = data_q;
    always_comb begin
        state_d   = state_q;
        post_d    = post_q;
        armed_d   = armed_q;
        trig_d    = trig_q;
        done_d    = done_q;
        abrt_d    = abrt_q;
        beat_last = 1'b0;
`ifdef CAPTURE_CTRL_PRE_EN
        pre_d     = pre_q;
`endif
        case (state_q)
            IDLE, DONE: if (ctl_arm) begin
                state_d = ARMED;
                armed_d = 1'b1;
                trig_d  = 1'b0;
                done_d  = 1'b0;
                abrt_d  = 1'b0;
`ifdef CAPTURE_CTRL_PRE_EN
                pre_d   = '0;
`endif
            end
            ARMED: if (ctl_abort) begin
                state_d = STOP;
                abrt_d  = 1'b1;
                armed_d = 1'b0;
            end else if (acc) begin
`ifdef CAPTURE_CTRL_PRE_EN
                pre_d = gate ? pre_q : pre_q + CNW'(1);
`endif
                if (sti_trigger && gate) begin
                    state_d   = (cfg_post == '0) ? STOP : TRIG;
                    beat_last = cfg_post == '0;
                    trig_d    = 1'b1;
                    armed_d   = 1'b0;
                    post_d    = cfg_post;
                end
            end
            TRIG: if (ctl_abort) begin
                state_d = STOP;
                abrt_d  = 1'b1;
            end else if (acc) begin
                post_d    = post_q - CNW'(1);
                beat_last = post_q == CNW'(1);
                state_d   = (post_q == CNW'(1)) ? STOP : TRIG;
            end
            STOP: if (!vld_q || sto_tready) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        vld_d  = load || (vld_q && !sto_tready);
        data_d = load ? sti_tdata : data_q;
        last_d = load ? beat_last : vld_d && (last_q || (ctl_abort && active));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            post_q  <= '0;
            armed_q <= 1'b0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
`ifdef CAPTURE_CTRL_PRE_EN
            pre_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            data_q  <= data_d;
            post_q  <= post_d;
            armed_q <= armed_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
`ifdef CAPTURE_CTRL_PRE_EN
            pre_q   <= pre_d;
`endif
        end
    end
endmodule
